// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the SPI LCD streaming transmitter.
// Holds the transmitter FSM state type and the default parameter values
// used by spi_lcd_stream and spi_tx_fifo.
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } lcd_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RST_CYCLES = 16;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous word FIFO holding {mode,data} entries for the SPI transmitter.
// Ports:
//   clk, nrst        system clock, asynchronous active-low reset
//   push, wdata      write request and entry; ignored while full
//   pop, rdata       read request and head entry (rdata is the current head)
//   full, empty      occupancy flags
//   level            current number of stored entries
module spi_tx_fifo
  import lcd_spi_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          push,
  input  logic [DATA_W:0]               wdata,
  input  logic                          pop,
  output logic [DATA_W:0]               rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            do_push, do_pop;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push while full is dropped even when a pop frees a slot in the same
  // cycle, so the producer only ever sees acceptance through ready.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/spi_lcd_stream.sv
// Streaming SPI transmitter for an LCD controller (SPI mode 0, MSB first).
// Words {mode,data} are buffered in a FIFO and shifted out with DC set from
// mode; consecutive buffered words are sent as one CS-low burst. After reset
// the LCD reset line is held low for RST_CYCLES clocks before any transfer.
// Ports:
//   clk, nrst          system clock, asynchronous active-low reset
//   data, mode, valid  producer word, DC value, and offer strobe
//   ready              FIFO not full (word accepted when valid & ready)
//   busy               init running, CS low, or words still buffered
//   level              FIFO occupancy
//   SCK, MOSI, DC, CS  SPI bus to the LCD (CS active low)
//   LCD_reset          LCD reset, active low
module spi_lcd_stream
  import lcd_spi_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [DATA_W-1:0]           data,
  input  logic                        mode,
  input  logic                        valid,
  output logic                        ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        SCK,
  output logic                        MOSI,
  output logic                        DC,
  output logic                        CS,
  output logic                        LCD_reset
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(RST_CYCLES + 1);
  localparam logic [BW-1:0] BIT_TOP   = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(RST_CYCLES - 1);

  logic            fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W:0] fifo_head;

  lcd_state_e      state_q, state_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [DATA_W-1:0] word_q, word_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            dc_q, dc_d;
  logic            cs_q, cs_d;
  logic            lcd_reset_q, lcd_reset_d;

  spi_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (valid),
    .wdata ({mode, data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ready     = ~fifo_full;
  assign busy      = (state_q == ST_INIT) | ~cs_q | ~fifo_empty;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;
  assign DC        = dc_q;
  assign CS        = cs_q;
  assign LCD_reset = lcd_reset_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_d      = word_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    dc_d        = dc_q;
    cs_d        = cs_q;
    lcd_reset_d = lcd_reset_q;
    fifo_pop    = 1'b0;
    bit_nxt     = bit_cnt_q - BW'(1);

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          lcd_reset_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end

      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end

      // DC and the first bit are only ever updated here, so they are settled
      // before the first SCK rise of the word.
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        cs_d      = 1'b0;
        dc_d      = fifo_head[DATA_W];
        word_d    = fifo_head[DATA_W-1:0];
        mosi_d    = fifo_head[DATA_W-1];
        bit_cnt_d = BIT_TOP;
        div_cnt_d = '0;
        sck_d     = 1'b0;
        state_d   = ST_SHIFT_LO;
      end

      ST_SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sck_d     = 1'b1;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      // End of a high phase is the SCK falling edge: the only point (apart
      // from LOAD) where MOSI advances to the next bit.
      ST_SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sck_d     = 1'b0;
          if (bit_cnt_q == '0) begin
            if (!fifo_empty) begin
              state_d = ST_LOAD;
            end else begin
              cs_d    = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            bit_cnt_d = bit_nxt;
            mosi_d    = word_q[bit_nxt];
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      dc_q        <= 1'b0;
      cs_q        <= 1'b1;
      lcd_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      dc_q        <= dc_d;
      cs_q        <= cs_d;
      lcd_reset_q <= lcd_reset_d;
    end
  end

  // Shift word is pure data; the bit counter and CS decide what is valid.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_spi_lcd_stream.sv
// Testbench for spi_lcd_stream: directed reset/latency/burst/abort scenarios
// plus a randomized stream. Accepted words go into an expected queue; an
// independent bus monitor reassembles words from SCK rising edges and
// compares each against the queue head.
module tb_spi_lcd_stream;

  localparam int DATA_W     = 8;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_CYCLES = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              mode = 1'b0;
  logic              valid = 1'b0;
  logic              ready, busy, SCK, MOSI, DC, CS, LCD_reset;
  logic [LW-1:0]     level;

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int words_done = 0;
  logic [DATA_W:0] sb [$];

  always #5 clk = ~clk;

  spi_lcd_stream #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .data      (data),
    .mode      (mode),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .level     (level),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .DC        (DC),
    .CS        (CS),
    .LCD_reset (LCD_reset)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected-response producer: every handshake enqueues the word that
  // must later appear on the bus as {DC, 8 MOSI bits}.
  always @(posedge clk) begin
    if (nrst && valid && ready) begin
      sb.push_back({mode, data});
      accepted++;
    end
  end

  // Bus monitor: rebuilds words from MOSI at SCK rises, checks SCK high time.
  logic              mon_prev_sck = 1'b0;
  int                mon_hi = 0;
  int                mon_nb = 0;
  logic [DATA_W-1:0] mon_bits = '0;
  logic              mon_dc0 = 1'b0;
  logic [DATA_W:0]   mon_exp;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!nrst) begin
        mon_prev_sck = 1'b0;
        mon_hi       = 0;
        mon_nb       = 0;
      end else begin
        if (SCK) mon_hi++;
        if (SCK && !mon_prev_sck) begin
          chk("cs_low_at_sck_rise", CS, 0);
          if (mon_nb == 0) mon_dc0 = DC;
          else chk("dc_stable_in_word", DC, mon_dc0);
          mon_bits = {mon_bits[DATA_W-2:0], MOSI};
          mon_nb++;
          if (mon_nb == DATA_W) begin
            mon_nb = 0;
            words_done++;
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_word: got 0x%0h, expected no word", {mon_dc0, mon_bits});
            end else begin
              mon_exp = sb.pop_front();
              chk("word_dc_bits", {mon_dc0, mon_bits}, mon_exp);
            end
          end
        end
        if (!SCK && mon_prev_sck) begin
          chk("sck_high_cycles", mon_hi, CLK_DIV);
          mon_hi = 0;
        end
        mon_prev_sck = SCK;
      end
    end
  end

  // Count SCK rises from now until CS returns high, bounded.
  task automatic count_until_cs_high(output int pulses, output bit timeout);
    logic prev;
    pulses  = 0;
    timeout = 1'b1;
    prev    = SCK;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (SCK && !prev) pulses++;
      prev = SCK;
      if (CS) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_init_sequence(input string tag);
    repeat (RST_CYCLES - 1) tick();
    chk({tag, "_lcd_reset_held"}, LCD_reset, 0);
    chk({tag, "_busy_in_init"}, busy, 1);
    tick();
    chk({tag, "_lcd_reset_rise"}, LCD_reset, 1);
  endtask

  int   pulses;
  bit   to;
  int   exp_words;
  int   acc_before;
  logic prev_s;
  int   rises;

  initial begin
    exp_words = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_cs", CS, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_dc", DC, 0);
    chk("rst_lcd_reset", LCD_reset, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    nrst = 1'b1;
    check_init_sequence("init1");
    chk("busy_after_init", busy, 0);

    // Single word 0xA5, DC=1: CS low two edges after acceptance
    tick();
    data = 8'hA5; mode = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    exp_words++;
    chk("single_level_after_push", level, 1);
    chk("single_cs_edge_n", CS, 1);
    tick();
    chk("single_cs_edge_n1", CS, 1);
    tick();
    chk("single_cs_edge_n2", CS, 0);
    chk("single_dc", DC, 1);
    chk("single_first_mosi", MOSI, 1);
    count_until_cs_high(pulses, to);
    chk("single_timeout", to, 0);
    chk("single_pulses", pulses, 8);
    chk("single_sck_idle_done", SCK, 0);
    tick();
    chk("single_busy_end", busy, 0);

    // Burst pushed during INIT, then full FIFO and push-vs-pop
    @(posedge clk);
    #3 nrst = 1'b0;
    sb.delete();
    tick(); tick();
    @(negedge clk);
    nrst = 1'b1;
    valid = 1'b1; data = 8'h21; mode = 1'b0;
    tick();
    data = 8'h14;
    tick();
    data = 8'h0C;
    tick();
    data = 8'h80; mode = 1'b1;
    tick();
    exp_words += 4;
    chk("burst_ready_full", ready, 0);
    chk("burst_level_full", level, 4);
    chk("burst_lcd_reset_up", LCD_reset, 1);
    data = 8'h55; mode = 1'b1;
    tick();
    chk("burst_5th_refused_level", level, 4);
    tick();
    chk("full_pop_level", level, 3);
    chk("full_pop_ready", ready, 1);
    chk("burst_cs_low", CS, 0);
    chk("burst_first_dc", DC, 0);
    valid = 1'b0;
    count_until_cs_high(pulses, to);
    chk("burst_timeout", to, 0);
    chk("burst_pulses", pulses, 32);
    chk("burst_busy_end", busy, 0);

    // Reset in the middle of a word
    tick();
    data = 8'hFF; mode = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    rises = 0;
    prev_s = SCK;
    for (int i = 0; i < 300 && rises < 4; i++) begin
      tick();
      if (SCK && !prev_s) rises++;
      prev_s = SCK;
    end
    chk("abort_reached_bit3", rises, 4);
    @(posedge clk);
    #3 nrst = 1'b0;
    sb.delete();
    #1;
    chk("abort_cs", CS, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 1);
    chk("abort_ready", ready, 1);
    chk("abort_lcd_reset", LCD_reset, 0);
    tick(); tick();
    @(negedge clk);
    nrst = 1'b1;
    check_init_sequence("init2");
    rises = 0;
    prev_s = SCK;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (SCK && !prev_s) rises++;
      prev_s = SCK;
    end
    chk("abort_no_sck_after", rises, 0);
    chk("abort_cs_idle", CS, 1);

    // Randomized stream
    acc_before = accepted;
    for (int i = 0; i < 3000 && (accepted - acc_before) < 24; i++) begin
      valid = 1'($urandom_range(0, 1));
      data  = DATA_W'($urandom);
      mode  = 1'($urandom_range(0, 1));
      tick();
    end
    valid = 1'b0;
    exp_words += accepted - acc_before;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    chk("random_drain_timeout", to, 0);
    tick();
    chk("random_sb_empty", sb.size(), 0);
    chk("words_seen", words_done, exp_words);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
